ste_lmc1992: RTL
================

// Module: ste_lmc1992
// PURPOSE
// - Downstream consumer of the STE DMA sound block. Receives its microwire serial stream
//   (mw_clk/mw_data/mw_done) and its 8-bit offset-binary stereo samples (audio_l/audio_r).
// - Decodes LMC1992 volume commands and applies master plus per-channel attenuation in 2 dB steps.
// - Drives signed 16-bit PCM to the audio output mixer.
// PARAMETERS
// - SYNC_STAGES  2  flip-flop stages synchronising mw_clk/mw_data/mw_done into clk32
// - MAX_BITS     16 bit-counter saturation value; longer frames are rejected
// PORTS
// - clk32        in   1   32 MHz system clock
// - reset        in   1   synchronous, active-high reset
// - mw_clk       in   1   microwire clock from DMA sound (8 MHz domain); bit sampled on its rise
// - mw_data      in   1   microwire data, MSB first
// - mw_done      in   1   end-of-transfer pulse from DMA sound
// - audio_l      in   8   left sample, offset binary (0x80 = silence)
// - audio_r      in   8   right sample, offset binary
// - ym_audio     in   8   YM2149 mix input, unsigned (LMC_MIXER_EN only)
// - pcm_l        out  16  attenuated left, signed
// - pcm_r        out  16  attenuated right, signed
// - master_vol   out  6   current master volume, 0..40
// - left_vol     out  5   current left volume, 0..20
// - right_vol    out  5   current right volume, 0..20
// BEHAVIOUR
// - Reset: master_vol=40, left_vol=20, right_vol=20 (0 dB); pcm_l/pcm_r=0; shift reg, bit_cnt, sync FFs=0.
// - Sync: mw_* pass through SYNC_STAGES FFs. Edge detect on synced mw_clk rise and synced mw_done rise.
// - Receive: each mw_clk rise -> shreg <= {shreg[9:0], mw_data_s}; bit_cnt++ (saturates at MAX_BITS).
// - Commit on mw_done rise. Valid only if bit_cnt==11 and shreg[10:9]==2'b10.
//   Otherwise the frame is discarded. bit_cnt clears on every mw_done rise, valid or not.
// - Command decode, cmd=shreg[8:6], d=shreg[5:0]:
//   - 011: master_vol <= min(d,40)
//   - 100: right_vol <= min(d[4:0],20)
//   - 101: left_vol <= min(d[4:0],20)
//   - 000: mixer (see CONFIGURATION)
//   - 001 bass, 010 treble, 11x: accepted, no effect.
// - Register update takes effect the cycle after the commit edge.
// - Coincident mw_clk rise and mw_done rise in the same cycle: shift first, then evaluate the 11-bit check.
// - Gain, per channel: steps = (40-master_vol)+(20-chan_vol), range 0..60.
//   - sh = steps/3; f = steps%3.
//   - frac = 256 / 203 / 161 for f = 0 / 1 / 2 (0 / -2 / -4 dB).
// - Datapath, 3-cycle latency:
//   - S1: s = audio ^ 8'h80 (signed 8-bit); latch frac and sh.
//   - S2: p = s*frac (signed 17-bit).
//   - S3: pcm = (p >>> sh) truncated to 16 bits.
//   - At 0 dB, pcm = s<<8. Large attenuation floors to 0 or -1 (arithmetic shift).
// - Volume changes apply from the next S1 sample; no zero-cross smoothing.
// - Reset mid-frame: partial microwire frame lost; volumes return to defaults.
// CONFIGURATION
// - LMC_MIXER_EN defined:
//   - Port ym_audio exists; mixer command d[1:0] sets mix_sel: 00 = YM at -12 dB, 01 = YM at 0 dB, 10/11 = YM off.
//   - mix_sel resets to 01.
//   - ym_s = {1'b0, ym_audio} << 7 (0 dB) or << 5 (-12 dB), added in S3 to both channels after attenuation.
//   - Sum saturates to the signed 16-bit range; YM is not attenuated.
// - LMC_MIXER_EN undefined: no ym_audio port; mixer command ignored; pcm is the DMA path only.
// TESTING
// - Reset, audio_l=8'hFF -> pcm_l=16'h7F00 after 3 clk32; master_vol=40, left_vol=20.
// - Frame 11'b10_011_010100 (master=20) then done -> master_vol=20; audio_l=8'hFF gives steps=20, sh=6, f=2.
//   -> pcm_l = (127*161)>>>6 = 319.
// - Frame 11'b10_101_011110 (left=30) -> left_vol clamps to 20; right_vol unchanged.
// - 12-bit frame, or 11-bit frame with address 01 -> discarded; all volumes unchanged.
// - master=0, left=0, audio_l=8'h00 -> steps=60, sh=20 -> pcm_l=16'hFFFF (-1); audio_l=8'h80 -> 0.
// - LMC_MIXER_EN: mixer d=10, ym_audio=8'hFF, audio=8'h80 -> pcm=0.
//   mixer d=01 -> pcm=32640; audio_l=8'hFF -> saturates to 16'h7FFF.

Source files
------------

// File: rtl/ste_lmc1992_if.sv
// Sound-stream interface from the STE DMA sound block into the LMC1992 model.
// Carries the microwire serial control lines and the stereo sample bytes.
// Optional feature macro: LMC_MIXER_EN adds the YM2149 mix input ym_audio.
interface ste_lmc1992_if;
  logic       mw_clk;
  logic       mw_data;
  logic       mw_done;
  logic [7:0] audio_l;
  logic [7:0] audio_r;
`ifdef LMC_MIXER_EN
  logic [7:0] ym_audio;

  modport master (output mw_clk, mw_data, mw_done, audio_l, audio_r, ym_audio);
  modport slave  (input  mw_clk, mw_data, mw_done, audio_l, audio_r, ym_audio);
`else
  modport master (output mw_clk, mw_data, mw_done, audio_l, audio_r);
  modport slave  (input  mw_clk, mw_data, mw_done, audio_l, audio_r);
`endif
endinterface

// File: rtl/ste_lmc1992.sv
// LMC1992 volume/tone controller model for the STE sound path.
// Decodes 11-bit microwire frames (address 10) into master/left/right volume in 2 dB
// steps and attenuates the offset-binary DMA samples into signed 16-bit PCM through a
// 3-stage pipeline (S1 sign/gain latch, S2 multiply, S3 shift).
// Optional feature macro: LMC_MIXER_EN enables the YM2149 mix input and mixer command.
module ste_lmc1992 #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_BITS    = 16
) (
  input  logic               clk32,
  input  logic               reset,
  ste_lmc1992_if.slave       snd,
  output logic signed [15:0] pcm_l,
  output logic signed [15:0] pcm_r,
  output logic [5:0]         master_vol,
  output logic [4:0]         left_vol,
  output logic [4:0]         right_vol
);

  localparam int CNT_W = $clog2(MAX_BITS + 1);

  logic [SYNC_STAGES-1:0] clk_sync, data_sync, done_sync;
  logic                   mw_clk_d, mw_done_d;
  logic [10:0]            shreg, shreg_nx;
  logic [CNT_W-1:0]       bit_cnt, cnt_nx;
  logic                   clk_rise, done_rise, frame_ok;
  logic [2:0]             cmd;
  logic [5:0]             d;

  logic [5:0]             steps_l, steps_r;
  logic [4:0]             sh_l, sh_r;
  logic [8:0]             frac_l, frac_r;

  // Pipeline registers
  logic signed [7:0]      s1_l, s1_r;
  logic [8:0]             frac1_l, frac1_r;
  logic [4:0]             sh1_l, sh1_r, sh2_l, sh2_r;
  logic signed [16:0]     p2_l, p2_r;

  assign clk_rise  = clk_sync[SYNC_STAGES-1] & ~mw_clk_d;
  assign done_rise = done_sync[SYNC_STAGES-1] & ~mw_done_d;
  assign cmd       = shreg_nx[8:6];
  assign d         = shreg_nx[5:0];

  // Next shift-register state; a coincident clock rise shifts before the frame check.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    shreg_nx = shreg;
    cnt_nx   = bit_cnt;
    if (clk_rise) begin
      shreg_nx = {shreg[9:0], data_sync[SYNC_STAGES-1]};
      if (bit_cnt != CNT_W'(MAX_BITS))
        cnt_nx = bit_cnt + 1'b1;
    end
    frame_ok = done_rise && (cnt_nx == CNT_W'(11)) && (shreg_nx[10:9] == 2'b10);
  end

  // Attenuation split into whole 6 dB shifts and a residual 0/-2/-4 dB fraction.
  always_comb begin
    steps_l = (6'd40 - master_vol) + (6'd20 - {1'b0, left_vol});
    steps_r = (6'd40 - master_vol) + (6'd20 - {1'b0, right_vol});
    sh_l    = 5'(steps_l / 6'd3);
    sh_r    = 5'(steps_r / 6'd3);
    unique case (steps_l % 6'd3)
      6'd0:    frac_l = 9'd256;
      6'd1:    frac_l = 9'd203;
      default: frac_l = 9'd161;
    endcase
    unique case (steps_r % 6'd3)
      6'd0:    frac_r = 9'd256;
      6'd1:    frac_r = 9'd203;
      default: frac_r = 9'd161;
    endcase
  end

`ifdef LMC_MIXER_EN
  logic [1:0]         mix_sel;
  logic [7:0]         ym1;
  logic signed [17:0] ym2;

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)       return 16'sh7FFF;
    else if (v < -18'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction
`endif

  // Synchroniser, microwire receiver, volume registers and sample pipeline.
  always_ff @(posedge clk32) begin
    // NOTE: all state uses non-blocking assignments so the pipeline stages read pre-edge values.
    if (reset) begin
      clk_sync   <= '0;
      data_sync  <= '0;
      done_sync  <= '0;
      mw_clk_d   <= 1'b0;
      mw_done_d  <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      master_vol <= 6'd40;
      left_vol   <= 5'd20;
      right_vol  <= 5'd20;
      s1_l       <= '0;
      s1_r       <= '0;
      frac1_l    <= '0;
      frac1_r    <= '0;
      sh1_l      <= '0;
      sh1_r      <= '0;
      sh2_l      <= '0;
      sh2_r      <= '0;
      p2_l       <= '0;
      p2_r       <= '0;
      pcm_l      <= '0;
      pcm_r      <= '0;
`ifdef LMC_MIXER_EN
      mix_sel    <= 2'b01;
      ym1        <= '0;
      ym2        <= '0;
`endif
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0],  snd.mw_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], snd.mw_data};
      done_sync <= {done_sync[SYNC_STAGES-2:0], snd.mw_done};
      mw_clk_d  <= clk_sync[SYNC_STAGES-1];
      mw_done_d <= done_sync[SYNC_STAGES-1];

      shreg   <= shreg_nx;
      bit_cnt <= done_rise ? '0 : cnt_nx;

      if (frame_ok) begin
        unique case (cmd)
          3'b011:  master_vol <= (d > 6'd40) ? 6'd40 : d;
          3'b100:  right_vol  <= (d[4:0] > 5'd20) ? 5'd20 : d[4:0];
          3'b101:  left_vol   <= (d[4:0] > 5'd20) ? 5'd20 : d[4:0];
`ifdef LMC_MIXER_EN
          3'b000:  mix_sel    <= d[1:0];
`endif
          default: ;
        endcase
      end

      // S1: offset binary to signed, latch gain for this sample
      s1_l    <= $signed(snd.audio_l ^ 8'h80);
      s1_r    <= $signed(snd.audio_r ^ 8'h80);
      frac1_l <= frac_l;
      frac1_r <= frac_r;
      sh1_l   <= sh_l;
      sh1_r   <= sh_r;

      // S2: fractional gain
      p2_l  <= $signed({{9{s1_l[7]}}, s1_l}) * $signed({8'd0, frac1_l});
      p2_r  <= $signed({{9{s1_r[7]}}, s1_r}) * $signed({8'd0, frac1_r});
      sh2_l <= sh1_l;
      sh2_r <= sh1_r;

      // S3: whole-step shift (plus optional YM mix)
`ifdef LMC_MIXER_EN
      ym1 <= snd.ym_audio;
      unique case (mix_sel)
        2'b00:   ym2 <= $signed({10'd0, ym1} << 5);
        2'b01:   ym2 <= $signed({10'd0, ym1} << 7);
        default: ym2 <= '0;
      endcase
      pcm_l <= sat16(18'(p2_l >>> sh2_l) + ym2);
      pcm_r <= sat16(18'(p2_r >>> sh2_r) + ym2);
`else
      pcm_l <= 16'(p2_l >>> sh2_l);
      pcm_r <= 16'(p2_r >>> sh2_r);
`endif
    end
  end

endmodule
